// File: rtl/lsu_sram_ctrl.sv
// Load/store controller driving the master side of a single-port SRAM: alignment check,
// byte masks, store replication and load extension. Optional read timeout: LSU_TIMEOUT_EN.
module lsu_sram_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_misalign,
    output logic                    resp_timeout,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   sram_rd_addr,
    output logic                    sram_rd_en,
    input  logic                    sram_rd_valid,
    input  logic [DATA_WIDTH-1:0]   sram_rd_data,
    output logic [ADDR_WIDTH-1:0]   sram_wr_addr,
    output logic                    sram_wr_en,
    output logic [DATA_WIDTH-1:0]   sram_wr_data,
    output logic [DATA_WIDTH/8-1:0] sram_w_mask
);
    localparam int NUM_OF_BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic                    accept;
    logic                    fault;
    logic [NUM_OF_BYTES-1:0] mask_next;
    logic [DATA_WIDTH-1:0]   wdata_rep;
    logic [DATA_WIDTH-1:0]   rd_shifted;
    logic [DATA_WIDTH-1:0]   load_ext;
    logic                    rd_timeout;

    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [1:0]              size_reg;
    logic                    uns_reg;
    logic [1:0]              off_reg;
    logic [NUM_OF_BYTES-1:0] mask_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic                    misalign_reg;

    assign accept = (state_reg == IDLE) && req_valid;

    always_comb begin
        fault = 1'b0;
        case (req_size)
            2'd0:    fault = 1'b0;
            2'd1:    fault = req_addr[0];
            2'd2:    fault = |req_addr[1:0];
            default: fault = 1'b1;
        endcase
    end

    always_comb begin
        mask_next = '1;
        case (req_size)
            2'd0:    mask_next = {{(NUM_OF_BYTES-1){1'b0}}, 1'b1} << req_addr[1:0];
            2'd1:    mask_next = {{(NUM_OF_BYTES-2){1'b0}}, 2'b11} << req_addr[1:0];
            default: mask_next = '1;
        endcase
    end

    // Each byte lane carries the store byte/half that lands on it, so the mask alone selects the write.
    for (genvar gi = 0; gi < NUM_OF_BYTES; gi++) begin : g_lane
        always_comb begin
            case (req_size)
                2'd0:    wdata_rep[gi*8 +: 8] = req_wdata[7:0];
                2'd1:    wdata_rep[gi*8 +: 8] = req_wdata[(gi%2)*8 +: 8];
                default: wdata_rep[gi*8 +: 8] = req_wdata[gi*8 +: 8];
            endcase
        end
    end

    assign rd_shifted = sram_rd_data >> {off_reg, 3'b000};

    always_comb begin
        load_ext = rd_shifted;
        case (size_reg)
            2'd0: load_ext = uns_reg ? {{(DATA_WIDTH-8){1'b0}}, rd_shifted[7:0]}
                                     : {{(DATA_WIDTH-8){rd_shifted[7]}}, rd_shifted[7:0]};
            2'd1: load_ext = uns_reg ? {{(DATA_WIDTH-16){1'b0}}, rd_shifted[15:0]}
                                     : {{(DATA_WIDTH-16){rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_ext = rd_shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_reg;
    logic             timeout_reg;

    // Count reaches TIMEOUT_CYCLES at the end of this cycle; a same-cycle rd_valid still wins.
    assign rd_timeout = (state_reg == RD) && !sram_rd_valid
                        && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else if (accept) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else if (state_reg == RD && !sram_rd_valid) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (rd_timeout) begin
                timeout_reg <= 1'b1;
            end
        end
    end
`else
    assign rd_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (fault) begin
                        state_next = RESP;
                    end else if (req_we) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            WR:      state_next = IDLE;
            RD:      if (sram_rd_valid || rd_timeout) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg     <= '0;
            size_reg     <= 2'd0;
            uns_reg      <= 1'b0;
            off_reg      <= 2'd0;
            mask_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            misalign_reg <= 1'b0;
        end else if (accept) begin
            addr_reg     <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            size_reg     <= req_size;
            uns_reg      <= req_unsigned;
            off_reg      <= req_addr[1:0];
            mask_reg     <= mask_next;
            wdata_reg    <= wdata_rep;
            rdata_reg    <= '0;
            misalign_reg <= fault;
        end else if (state_reg == RD && sram_rd_valid) begin
            rdata_reg <= load_ext;
        end
    end

    always_comb begin
        req_ready     = (state_reg == IDLE);
        busy          = (state_reg != IDLE);
        sram_wr_en    = (state_reg == WR);
        sram_rd_en    = (state_reg == RD);
        sram_wr_addr  = sram_wr_en ? addr_reg  : '0;
        sram_wr_data  = sram_wr_en ? wdata_reg : '0;
        sram_w_mask   = sram_wr_en ? mask_reg  : '0;
        sram_rd_addr  = sram_rd_en ? addr_reg  : '0;
        resp_valid    = (state_reg == WR) || (state_reg == RESP);
        resp_rdata    = (state_reg == RESP) ? rdata_reg : '0;
        resp_misalign = (state_reg == RESP) && misalign_reg;
`ifdef LSU_TIMEOUT_EN
        resp_timeout  = (state_reg == RESP) && timeout_reg;
`else
        resp_timeout  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Bench for lsu_sram_ctrl: directed vector table, randomized traffic against a
// byte-lane reference model, plus reset-abort and (with LSU_TIMEOUT_EN) timeout sequences.
module tb_lsu_sram_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        resp_timeout;
    logic        busy;
    logic [31:0] sram_rd_addr;
    logic        sram_rd_en;
    logic        sram_rd_valid = 1'b0;
    logic [31:0] sram_rd_data = '0;
    logic [31:0] sram_wr_addr;
    logic        sram_wr_en;
    logic [31:0] sram_wr_data;
    logic [3:0]  sram_w_mask;

    lsu_sram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
        .resp_timeout(resp_timeout), .busy(busy),
        .sram_rd_addr(sram_rd_addr), .sram_rd_en(sram_rd_en), .sram_rd_valid(sram_rd_valid),
        .sram_rd_data(sram_rd_data), .sram_wr_addr(sram_wr_addr), .sram_wr_en(sram_wr_en),
        .sram_wr_data(sram_wr_data), .sram_w_mask(sram_w_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rd_data;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_mis;
        logic        e_to;
        int          e_lat;
        int          e_rd;
        int          e_wr;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;

    int          got, lat, rd_cyc, wr_cyc, both;
    logic [31:0] r_rdata, r_rd_addr, r_wr_addr, r_wr_data;
    logic [3:0]  r_mask;
    logic        r_mis, r_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: natural alignment, byte lanes [off, off+n) touched, little-endian lane order.
    function automatic vec_t model(input vec_t v);
        int     n, off;
        longint val;
        vec_t   r;
        r = v;
        off = int'(v.addr[1:0]);
        n = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        r.e_mis = (v.size == 2'd3) || ((off % n) != 0);
        r.e_addr = v.addr & 32'hFFFF_FFFC;
        r.e_mask = '0; r.e_wdata = '0; r.e_rdata = '0; r.e_to = 1'b0;
        r.e_rd = 0; r.e_wr = 0; r.e_lat = 1;
        if (!r.e_mis && v.we) begin
            r.e_wr = 1;
            for (int i = 0; i < 4; i++) begin
                r.e_mask[i] = (i >= off) && (i < off + n);
                r.e_wdata[8*i +: 8] = v.wdata[8*(i % n) +: 8];
            end
        end else if (!r.e_mis) begin
            r.e_rd = v.delay + 1;
            r.e_lat = v.delay + 2;
            val = 0;
            for (int i = 0; i < n; i++) begin
                val = val | (longint'(v.rd_data[8*(off+i) +: 8]) << (8*i));
            end
            if (!v.uns && val[8*n-1]) val = val - (64'sd1 <<< (8*n));
            r.e_rdata = val[31:0];
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        int cyc;
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        #1;
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1; got = 0; rd_cyc = 0; wr_cyc = 0; both = 0;
        r_rdata = '0; r_mis = 1'b0; r_to = 1'b0;
        r_rd_addr = '0; r_wr_addr = '0; r_wr_data = '0; r_mask = '0;
        while (got == 0 && cyc <= 40) begin
            if (sram_rd_en && rd_cyc == v.delay) begin
                sram_rd_valid = 1'b1; sram_rd_data = v.rd_data;
            end else begin
                sram_rd_valid = sram_rd_en ? 1'b0 : 1'($urandom_range(0, 1));
                sram_rd_data = $urandom;
            end
            @(negedge clk);
            if (sram_rd_en) begin rd_cyc++; r_rd_addr = sram_rd_addr; end
            if (sram_wr_en) begin
                wr_cyc++; r_wr_addr = sram_wr_addr; r_wr_data = sram_wr_data; r_mask = sram_w_mask;
            end
            if (sram_rd_en && sram_wr_en) both = 1;
            if (resp_valid) begin
                got = 1; lat = cyc;
                r_rdata = resp_rdata; r_mis = resp_misalign; r_to = resp_timeout;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("resp_seen", got, 1);
        @(posedge clk); #1;
        sram_rd_valid = 1'b0;
        @(negedge clk);
        check("resp_pulse", {31'b0, resp_valid}, 32'd0);
        check("ready_after", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic check_txn(input vec_t v);
        run_txn(v);
        n_txn++;
        $display("txn %0d we=%0d size=%0d uns=%0d addr=%h wdata=%h lat=%0d rd=%0d wr=%0d rdata=%h mis=%0d to=%0d",
                 n_txn, v.we, v.size, v.uns, v.addr, v.wdata, lat, rd_cyc, wr_cyc, r_rdata, r_mis, r_to);
        check("latency", lat, v.e_lat);
        check("rd_cycles", rd_cyc, v.e_rd);
        check("wr_cycles", wr_cyc, v.e_wr);
        check("en_overlap", both, 0);
        check("resp_rdata", r_rdata, v.e_rdata);
        check("resp_misalign", {31'b0, r_mis}, {31'b0, v.e_mis});
        check("resp_timeout", {31'b0, r_to}, {31'b0, v.e_to});
        if (v.e_rd > 0) check("rd_addr", r_rd_addr, v.e_addr);
        if (v.e_wr > 0) begin
            check("wr_addr", r_wr_addr, v.e_addr);
            check("wr_data", r_wr_data, v.e_wdata);
            check("w_mask", {28'b0, r_mask}, {28'b0, v.e_mask});
        end
    endtask

    vec_t tbl[10];
    vec_t v;

    initial begin
        //          we    size  uns   addr          wdata         dly rd_data       e_addr        mask     e_wdata       e_rdata       mis   to    lat rd wr
        tbl[0] = '{1'b1, 2'd2, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'h0,        32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0, 1, 0, 1};
        tbl[1] = '{1'b1, 2'd0, 1'b0, 32'h0000_2003, 32'h0000_00A5, 0, 32'h0,        32'h0000_2000, 4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0, 1, 0, 1};
        tbl[2] = '{1'b0, 2'd0, 1'b0, 32'h0000_3001, 32'h0,         2, 32'h0000_8000, 32'h0000_3000, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0, 4, 3, 0};
        tbl[3] = '{1'b0, 2'd0, 1'b1, 32'h0000_3001, 32'h0,         2, 32'h0000_8000, 32'h0000_3000, 4'b0000, 32'h0,        32'h0000_0080, 1'b0, 1'b0, 4, 3, 0};
        tbl[4] = '{1'b0, 2'd1, 1'b0, 32'h0000_4002, 32'h0,         0, 32'h8001_1234, 32'h0000_4000, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0, 2, 1, 0};
        tbl[5] = '{1'b0, 2'd2, 1'b0, 32'h0000_5002, 32'h0,         0, 32'h1111_1111, 32'h0000_5000, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1, 0, 0};
        tbl[6] = '{1'b0, 2'd3, 1'b0, 32'h0000_6000, 32'h0,         0, 32'h2222_2222, 32'h0000_6000, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1, 0, 0};
        tbl[7] = '{1'b1, 2'd1, 1'b0, 32'h0000_7002, 32'h1234_BEEF, 0, 32'h0,        32'h0000_7000, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0, 1'b0, 1, 0, 1};
        tbl[8] = '{1'b0, 2'd1, 1'b1, 32'h0000_8000, 32'h0,         1, 32'h1234_F00D, 32'h0000_8000, 4'b0000, 32'h0,        32'h0000_F00D, 1'b0, 1'b0, 3, 2, 0};
        tbl[9] = '{1'b1, 2'd3, 1'b0, 32'h0000_9001, 32'h5555_AAAA, 0, 32'h0,        32'h0000_9000, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1, 0, 0};

        // Reset state
        #3;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rd_en", {31'b0, sram_rd_en}, 32'd0);
        check("rst_wr_en", {31'b0, sram_wr_en}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_wr_data", sram_wr_data, 32'd0);
        check("rst_w_mask", {28'b0, sram_w_mask}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) check_txn(tbl[i]);

        for (int i = 0; i < 150; i++) begin
            v.we = 1'($urandom_range(0, 1));
            v.size = 2'($urandom_range(0, 3));
            v.uns = 1'($urandom_range(0, 1));
            v.addr = $urandom;
            if ($urandom_range(0, 3) != 0) v.addr[1:0] = (v.size == 2'd0) ? v.addr[1:0] : (v.size == 2'd1) ? {v.addr[1], 1'b0} : 2'b00;
            v.wdata = $urandom;
            v.delay = $urandom_range(0, 2);
            v.rd_data = $urandom;
            check_txn(model(v));
        end

        // Reset during RD: everything drops at once, no response for the aborted load
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_A000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_rd_en_before", {31'b0, sram_rd_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_rd_en", {31'b0, sram_rd_en}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_req_ready", {31'b0, req_ready}, 32'd1);
        check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int resp_cnt = 0;
            int rden_cnt = 0;
            sram_rd_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (resp_valid) resp_cnt++;
                if (sram_rd_en) rden_cnt++;
            end
            sram_rd_valid = 1'b0;
            check("abort_no_resp", resp_cnt, 0);
            check("idle_rd_valid_ignored", rden_cnt, 0);
        end
        $display("txn reset-abort during RD at addr=0000a000");

`ifdef LSU_TIMEOUT_EN
        v = model('{1'b0, 2'd2, 1'b0, 32'h0000_B000, 32'h0, 1000, 32'h0,
                    32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0, 0});
        v.e_rd = TO; v.e_lat = TO + 1; v.e_to = 1'b1; v.e_rdata = 32'h0;
        check_txn(v);
        // rd_valid on the last allowed cycle beats the timeout
        v = model('{1'b0, 2'd2, 1'b0, 32'h0000_B004, 32'h0, TO - 1, 32'hCAFE_F00D,
                    32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0, 0});
        check_txn(v);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
